// File: rtl/cube_sqrt_alu_if.sv
// Start/busy/done handshake and operand/result bus of the cube/sqrt ALU.
interface cube_sqrt_alu_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic                   start_i;
  logic [1:0]             mode_bi;
  logic [WIDTH-1:0]       a_bi;
  logic [WIDTH-1:0]       b_bi;
  logic                   busy_o;
  logic                   done_o;
  logic [3*WIDTH-1:0]     y_bo;

  // Requester side (lab top level / testbench)
  modport master (
    output start_i, mode_bi, a_bi, b_bi,
    input  busy_o, done_o, y_bo
  );

  // Arithmetic unit side
  modport slave (
    input  start_i, mode_bi, a_bi, b_bi,
    output busy_o, done_o, y_bo
  );
endinterface

// File: rtl/cube_sqrt_alu.sv
// Multi-cycle unit: a^3+floor(sqrt(b)), a^3, floor(sqrt(b)) or a*b.
// Shift-add multiplier (one multiplier bit per edge, LSB first) and a
// restoring square root (two radicand bits per edge, MSB pair first).
module cube_sqrt_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  cube_sqrt_alu_if.slave bus
);

  localparam int unsigned RW = 3 * WIDTH;        // result / partial-sum width
  localparam int unsigned HW = WIDTH / 2;        // root width
  localparam int unsigned SW = HW + 3;           // shifted remainder width
  localparam int unsigned CW = $clog2(WIDTH) + 1; // step counter width

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL1,
    S_MUL2,
    S_SQRT,
    S_FIN
  } state_t;

  state_t            state, state_nxt;

  logic [WIDTH-1:0]  a_r;
  logic [1:0]        mode_r;
  logic [RW-1:0]     acc;
  logic [RW-1:0]     mcand;
  logic [WIDTH-1:0]  mplier;
  logic [CW-1:0]     cnt;

  logic [SW-3:0]     rem;
  logic [HW-1:0]     root;
  logic [WIDTH-1:0]  rad;

  logic [RW-1:0]     y_r;
  logic              done_r;

  logic [RW-1:0]     acc_step;
  logic [SW-1:0]     rem_sh;
  logic [SW-1:0]     trial;
  logic              sq_ge;
  logic              sq_en;
  logic              last_mul;
  logic              last_sqrt;
  logic [RW-1:0]     result;

  // Per-edge arithmetic: multiply step, square-root step and final result
  always_comb begin
    acc_step  = mplier[0] ? (acc + mcand) : acc;
    rem_sh    = {rem, rad[WIDTH-1 -: 2]};
    trial     = {1'b0, root, 2'b01};
    sq_ge     = (rem_sh >= trial);
    last_mul  = (cnt == CW'(WIDTH - 1));
    last_sqrt = (cnt == CW'(HW - 1));
    // In mode 00 the root is built during the first half of MUL1.
    sq_en     = (state == S_SQRT) ||
                ((state == S_MUL1) && (mode_r == 2'b00) && (cnt < CW'(HW)));
    case (mode_r)
      2'b00:   result = acc + RW'(root);
      2'b10:   result = RW'(root);
      default: result = acc;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.start_i) state_nxt = (bus.mode_bi == 2'b10) ? S_SQRT : S_MUL1;
      end
      S_MUL1: begin
        if (last_mul) state_nxt = (mode_r == 2'b11) ? S_FIN : S_MUL2;
      end
      S_MUL2: begin
        if (last_mul) state_nxt = S_FIN;
      end
      S_SQRT: begin
        if (last_sqrt) state_nxt = S_FIN;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, multiplier and square-root datapath, result register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      a_r    <= '0;
      mode_r <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      rem    <= '0;
      root   <= '0;
      rad    <= '0;
      y_r    <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;

      if (sq_en) begin
        rem  <= sq_ge ? (SW-2)'(rem_sh - trial) : (SW-2)'(rem_sh);
        root <= {root[HW-2:0], sq_ge};
        rad  <= rad << 2;
      end

      case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            a_r    <= bus.a_bi;
            mode_r <= bus.mode_bi;
            acc    <= '0;
            mcand  <= RW'(bus.a_bi);
            mplier <= (bus.mode_bi == 2'b11) ? bus.b_bi : bus.a_bi;
            cnt    <= '0;
            rem    <= '0;
            root   <= '0;
            rad    <= bus.b_bi;
          end
        end
        S_MUL1: begin
          // End of a*a: the square becomes the multiplicand of the a*a*a pass.
          if (last_mul && (mode_r != 2'b11)) begin
            acc    <= '0;
            mcand  <= acc_step;
            mplier <= a_r;
            cnt    <= '0;
          end else begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= last_mul ? '0 : cnt + 1'b1;
          end
        end
        S_MUL2: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= last_mul ? '0 : cnt + 1'b1;
        end
        S_SQRT: begin
          cnt <= last_sqrt ? '0 : cnt + 1'b1;
        end
        S_FIN: begin
          y_r    <= result;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o = (state != S_IDLE);
  assign bus.done_o = done_r;
  assign bus.y_bo   = y_r;

endmodule
